obj_linebuffer_pair: RTL and testbench
======================================

// Module: obj_linebuffer_pair
// PURPOSE
//  Double-banked object line buffer directly downstream of the 005294 line latch.
//  Accepts the latch's DA/DB pixel pair (even/odd screen pixel, {palette,pixel} bytes) each write slot.
//  Stores each pair into the bank being drawn; streams the other bank to the video mixer one pixel per read.
//  Clears each word after it is read, so the bank is empty when it becomes the draw bank again.
// PARAMETERS
//  XW   9   screen x width in pixels (2^XW pixels per line; 2^(XW-1) pair words per bank)
// PORTS
//  i_EMU_MCLK          in   1      master clock
//  i_RST               in   1      synchronous reset, active high
//  i_EMU_CLK6MPCEN_n   in   1      6 MHz clock enable, active low; all RUN activity gated by it
//  i_LINESWAP          in   1      line boundary strobe: swap draw/display banks
//  i_WR_EN             in   1      pixel pair valid this enable tick
//  i_WR_ADDR           in   XW-1   pair word address (screen x >> 1)
//  i_DA                in   8      even pixel {palette[7:4], pixel[3:0]}
//  i_DB                in   8      odd pixel  {palette[7:4], pixel[3:0]}
//  i_RD_EN             in   1      advance display pointer one pixel
//  o_PIXEL             out  8      display pixel {palette, pixel}
//  o_OPAQUE            out  1      o_PIXEL[3:0] != 0
//  o_READY             out  1      high once power-on clear finished
// BEHAVIOUR
//  Storage: two banks, 2^(XW-1) words x 16 bits {A[7:0], B[7:0]}; wbank selects draw bank, ~wbank display bank.
//  Reset (i_RST=1): state=CLEAR, clr_addr=0, wbank=0, rd_ptr=0, o_PIXEL=8'h00, o_OPAQUE=0, o_READY=0.
//  FSM CLEAR: every MCLK (ungated by CE) writes 16'h0000 to clr_addr in both banks, clr_addr++;
//   after last address (all ones) -> RUN, o_READY=1 next MCLK. Total 2^(XW-1) MCLKs.
//   In CLEAR: writes, reads, LINESWAP ignored; o_PIXEL held 0.
//  FSM RUN (all actions only on MCLK with CE low):
//  - Write: i_WR_EN=1 -> lane A written with i_DA iff i_DA[3:0]!=0; lane B with i_DB iff i_DB[3:0]!=0.
//    Zero nibble = transparent, lane left unchanged (byte-lane write enables).
//  - Read: i_RD_EN=1 -> o_PIXEL/o_OPAQUE register lane rd_ptr[0] (0=A,1=B) of word rd_ptr[XW-1:1],
//    display bank; valid 1 CE tick after request (latency 1). rd_ptr++, wraps 2^XW-1 -> 0.
//  - Clear-after-read: reading an odd pixel (rd_ptr[0]=1) writes 16'h0000 to that word in display bank.
//  - i_RD_EN=0: o_PIXEL/o_OPAQUE hold.
//  - LINESWAP: wbank toggles, rd_ptr=0; o_PIXEL holds.
//  Simultaneous events (same CE tick):
//  - LINESWAP+WR_EN: write lands in the bank that was draw bank before the swap.
//  - LINESWAP+RD_EN: LINESWAP wins; no read, no clear, rd_ptr=0.
//  - Write and read/clear always target different banks; no address conflict possible.
//  - i_RST asserted mid-line: immediate return to CLEAR; buffered pixels discarded.
//  Partial line read (swap before rd_ptr wraps): unread words are not cleared; they persist into next draw.
// CONFIGURATION
//  OBJLB_PRIORITY_EN defined: a lane is written only if its stored nibble [3:0] is 0 (first-drawn object wins;
//   lower-numbered sprites keep priority). Undefined: last opaque write wins (overwrite).
//  Byte-lane transparency skip applies in both builds.
// TESTING
//  1 Reset, count MCLKs -> o_READY rises after exactly 256 MCLKs (XW=9); o_PIXEL=0 throughout.
//  2 Write addr 5 DA=8'h3A DB=8'h40, LINESWAP, read 12 px -> px10=8'h3A (OPAQUE=1), px11=8'h00 (OPAQUE=0, B transparent).
//  3 Write addr 5 DA=8'h3A then DA=8'h51; without macro px10=8'h51; with OBJLB_PRIORITY_EN px10=8'h3A.
//  4 Full line read of bank, 2 LINESWAPs, read again with no writes -> all 512 px 8'h00 (clear-after-read).
//  5 LINESWAP and RD_EN same tick -> rd_ptr=0, o_PIXEL unchanged; WR_EN same tick -> data appears after next swap.
//  6 Assert i_RST after 100 px of a written line -> o_READY=0, then all reads 8'h00 after clear completes.

Source files
------------

// File: rtl/obj_linebuffer_pair.sv
// Double-banked object line buffer: draws latched pixel pairs into one bank while streaming and clearing the other.
// Optional build macro OBJLB_PRIORITY_EN: first opaque pixel drawn into a lane wins instead of the last.
module obj_linebuffer_pair #(
   parameter int XW = 9
) (
   input  logic          i_EMU_MCLK,
   input  logic          i_RST,
   input  logic          i_EMU_CLK6MPCEN_n,
   input  logic          i_LINESWAP,
   input  logic          i_WR_EN,
   input  logic [XW-2:0] i_WR_ADDR,
   input  logic [7:0]    i_DA,
   input  logic [7:0]    i_DB,
   input  logic          i_RD_EN,
   output logic [7:0]    o_PIXEL,
   output logic          o_OPAQUE,
   output logic          o_READY
);

   localparam int DEPTH = 2 ** (XW - 1);
   localparam logic [XW-2:0] CLR_ONE = 1;
   localparam logic [XW-1:0] RD_ONE  = 1;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t        state, state_nx;
   logic [XW-2:0] clr_addr;
   logic          wbank;
   logic [XW-1:0] rd_ptr;
   logic [15:0]   mem [2][DEPTH];

   logic          run_tick, do_swap, do_write, do_read;
   logic          wr_a, wr_b;
   logic [XW-2:0] rd_word;
   logic [15:0]   draw_word, disp_word;
   logic [7:0]    rd_pixel;

   assign run_tick  = (state == ST_RUN) && !i_EMU_CLK6MPCEN_n;
   assign do_swap   = run_tick && i_LINESWAP;
   assign do_write  = run_tick && i_WR_EN;
   assign do_read   = run_tick && i_RD_EN && !i_LINESWAP;
   assign rd_word   = rd_ptr[XW-1:1];
   assign draw_word = mem[wbank][i_WR_ADDR];
   assign disp_word = mem[~wbank][rd_word];
   assign rd_pixel  = rd_ptr[0] ? disp_word[7:0] : disp_word[15:8];
   assign o_READY   = (state == ST_RUN);

   // Zero pixel nibble means transparent: that byte lane keeps its old contents.
`ifdef OBJLB_PRIORITY_EN
   assign wr_a = do_write && (i_DA[3:0] != 4'h0) && (draw_word[11:8] == 4'h0);
   assign wr_b = do_write && (i_DB[3:0] != 4'h0) && (draw_word[3:0] == 4'h0);
`else
   assign wr_a = do_write && (i_DA[3:0] != 4'h0);
   assign wr_b = do_write && (i_DB[3:0] != 4'h0);
`endif

   always_ff @(posedge i_EMU_MCLK) begin
      if (i_RST) state <= ST_CLEAR;
      else       state <= state_nx;
   end

   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         ST_CLEAR: if (&clr_addr) state_nx = ST_RUN;
         ST_RUN:   state_nx = ST_RUN;
         default:  state_nx = ST_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_EMU_MCLK) begin
      if (i_RST) begin
         clr_addr <= '0;
         wbank    <= 1'b0;
         rd_ptr   <= '0;
         o_PIXEL  <= 8'h00;
         o_OPAQUE <= 1'b0;
      end else begin
         if (state == ST_CLEAR) clr_addr <= clr_addr + CLR_ONE;
         if (do_swap) begin
            wbank  <= ~wbank;
            rd_ptr <= '0;
         end else if (do_read) begin
            o_PIXEL  <= rd_pixel;
            o_OPAQUE <= (rd_pixel[3:0] != 4'h0);
            rd_ptr   <= rd_ptr + RD_ONE;
         end
      end
   end

   // NOTE: storage has no reset term; the CLEAR sweep zeroes it, keeping it mappable to block RAM.
   always_ff @(posedge i_EMU_MCLK) begin
      if (!i_RST) begin
         if (state == ST_CLEAR) begin
            mem[0][clr_addr] <= 16'h0000;
            mem[1][clr_addr] <= 16'h0000;
         end
         if (wr_a) mem[wbank][i_WR_ADDR][15:8] <= i_DA;
         if (wr_b) mem[wbank][i_WR_ADDR][7:0]  <= i_DB;
         // Odd pixel is the last one of its word, so the word can be emptied for the next draw.
         if (do_read && rd_ptr[0]) mem[~wbank][rd_word] <= 16'h0000;
      end
   end

endmodule

// File: tb/tb_obj_linebuffer_pair.sv
// Self-checking bench for obj_linebuffer_pair: pixel-level line model checked every cycle plus directed literals.
module tb_obj_linebuffer_pair;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce_n = 1'b1;
   logic       lineswap = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] da = '0;
   logic [7:0] db = '0;
   logic       rd_en = 1'b0;
   logic [7:0] pixel;
   logic       opaque;
   logic       ready;

   int n_checks = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   obj_linebuffer_pair #(.XW(9)) dut (
      .i_EMU_MCLK(clk), .i_RST(rst), .i_EMU_CLK6MPCEN_n(ce_n), .i_LINESWAP(lineswap),
      .i_WR_EN(wr_en), .i_WR_ADDR(wr_addr), .i_DA(da), .i_DB(db), .i_RD_EN(rd_en),
      .o_PIXEL(pixel), .o_OPAQUE(opaque), .o_READY(ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each bank is a line of 512 pixels; a line becomes empty as its odd pixels are read.
   logic [7:0] mb [2][512];
   int         clr_cnt = 256;
   int         wb = 0;
   int         rp = 0;
   logic [7:0] m_pix = 8'h00;
   bit         m_opq = 1'b0;
   int         pa;
   bit         free_a, free_b;

   always @(posedge clk) begin
      if (rst) begin
         clr_cnt = 256; wb = 0; rp = 0; m_pix = 8'h00; m_opq = 1'b0;
         foreach (mb[b, p]) mb[b][p] = 8'h00;
      end else if (clr_cnt > 0) begin
         clr_cnt--;
      end else if (!ce_n) begin
         if (wr_en) begin
            pa = 2 * int'(wr_addr);
`ifdef OBJLB_PRIORITY_EN
            free_a = (mb[wb][pa][3:0] == 4'h0);
            free_b = (mb[wb][pa+1][3:0] == 4'h0);
`else
            free_a = 1'b1;
            free_b = 1'b1;
`endif
            if (da[3:0] != 4'h0 && free_a) mb[wb][pa] = da;
            if (db[3:0] != 4'h0 && free_b) mb[wb][pa+1] = db;
         end
         if (lineswap) begin
            wb = 1 - wb;
            rp = 0;
         end else if (rd_en) begin
            m_pix = mb[1-wb][rp];
            m_opq = (m_pix[3:0] != 4'h0);
            if (rp % 2 == 1) begin
               mb[1-wb][rp] = 8'h00;
               mb[1-wb][rp-1] = 8'h00;
            end
            rp = (rp + 1) % 512;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_ready", ready, (clr_cnt == 0));
         check("cyc_pixel", pixel, m_pix);
         check("cyc_opaque", opaque, m_opq);
      end
   end

   task automatic tick(input bit ce, input bit sw, input bit wr, input logic [7:0] addr,
                       input logic [7:0] a, input logic [7:0] b, input bit rd);
      @(negedge clk);
      ce_n = !ce; lineswap = sw; wr_en = wr; wr_addr = addr; da = a; db = b; rd_en = rd;
      @(posedge clk);
      #1;
      ce_n = 1'b1; lineswap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic read_px(output logic [7:0] p, output logic o);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      p = pixel;
      o = opaque;
   endtask

   task automatic swap();
      tick(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic write_pair(input logic [7:0] addr, input logic [7:0] a, input logic [7:0] b);
      tick(1'b1, 1'b0, 1'b1, addr, a, b, 1'b0);
   endtask

   task automatic wait_ready(input string name);
      int cnt = 0;
      int bad = 0;
      while (!ready && cnt < 1000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (pixel != 8'h00) bad++;
      end
      check({name, "_ready_latency"}, cnt, 256);
      check({name, "_pixel_zero_in_clear"}, bad, 0);
   endtask

   task automatic read_zero_line(input string name);
      logic [7:0] p;
      logic o;
      int nz = 0;
      for (int i = 0; i < 512; i++) begin
         read_px(p, o);
         if (p != 8'h00 || o) nz++;
      end
      check(name, nz, 0);
   endtask

   initial begin
      logic [7:0] p;
      logic o;

      // 1: power-on clear
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("t1_ready_in_reset", ready, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready("t1");

      // 2: single pair with transparent B lane; a CE-gated write must be ignored
      write_pair(8'd5, 8'h3A, 8'h40);
      swap();
      tick(1'b0, 1'b0, 1'b1, 8'd6, 8'h11, 8'h22, 1'b1);
      for (int i = 0; i < 12; i++) begin
         read_px(p, o);
         if (i == 10) begin
            check("t2_px10", p, 8'h3A);
            check("t2_px10_opaque", o, 1);
         end
         if (i == 11) begin
            check("t2_px11", p, 8'h00);
            check("t2_px11_opaque", o, 0);
         end
      end

      // 3: overlapping writes to one lane
      write_pair(8'd5, 8'h3A, 8'h00);
      write_pair(8'd5, 8'h51, 8'h00);
      write_pair(8'd200, 8'h12, 8'h34);
      swap();
      for (int i = 0; i < 12; i++) begin
         read_px(p, o);
`ifdef OBJLB_PRIORITY_EN
         if (i == 10) check("t3_px10", p, 8'h3A);
`else
         if (i == 10) check("t3_px10", p, 8'h51);
`endif
         if (i == 11) check("t3_px11", p, 8'h00);
      end

      // 4: finish the line, then the same bank must read back empty
      for (int i = 12; i < 512; i++) begin
         read_px(p, o);
         if (i == 400) check("t4_px400", p, 8'h12);
         if (i == 401) check("t4_px401", p, 8'h34);
      end
      swap();
      swap();
      read_zero_line("t4_cleared_line");

      // 5: swap coincident with read and write
      write_pair(8'd3, 8'h77, 8'h88);
      swap();
      for (int i = 0; i < 7; i++) read_px(p, o);
      check("t5_px6", p, 8'h77);
      tick(1'b1, 1'b1, 1'b1, 8'd9, 8'h1F, 8'h2E, 1'b1);
      check("t5_hold_on_swap", pixel, 8'h77);
      for (int i = 0; i < 20; i++) begin
         read_px(p, o);
         if (i == 18) check("t5_px18", p, 8'h1F);
         if (i == 19) check("t5_px19", p, 8'h2E);
      end
      swap();
      for (int i = 0; i < 8; i++) begin
         read_px(p, o);
         if (i == 6) check("t5_persist_px6", p, 8'h77);
         if (i == 7) check("t5_persist_px7", p, 8'h88);
      end

      // 6: reset in the middle of a displayed line
      write_pair(8'd49, 8'h4C, 8'h5D);
      write_pair(8'd60, 8'h4C, 8'h5D);
      swap();
      for (int i = 0; i < 100; i++) read_px(p, o);
      check("t6_px99", p, 8'h5D);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_ready_dropped", ready, 0);
      check("t6_pixel_reset", pixel, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      wait_ready("t6");
      read_zero_line("t6_bank_a_empty");
      swap();
      read_zero_line("t6_bank_b_empty");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
